rom_error_gen: RTL and testbench

Parametrised successor of the ROM-reference error stage. It steps a reference-table address on each sample strobe and reads an external synchronous ROM. It scales the ROM word by a runtime fixed-point gain and outputs e0 = vref - gain*rom as a saturated signed integer with a valid strobe. The whole pipeline is in fixed point, runs in one clock domain, and supports continuous or one-shot playback with start-of-frame marking. It sits between the reference ROM and the controller's error consumer.

---
 rtl/rom_error_pkg.sv | 39 +++
 rtl/rom_error_dp.sv | 109 ++++++++++
 rtl/rom_error_gen.sv | 119 +++++++++++
 tb/tb_rom_error_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_error_pkg.sv
// -----------------------------------------------------------------------------
// rom_error_pkg
// Shared definitions for the ROM-reference error stage:
//   - default parameter values for rom_error_gen / rom_error_dp
//   - LAT     : fs_en-to-e0_valid latency for the default ROM latency
//   - mode_e  : playback mode state (running / one-shot finished)
//   - sat_s() : signed saturation of a wide value to a w-bit signed range
// -----------------------------------------------------------------------------
package rom_error_pkg;

    localparam int unsigned DATA_W_DEF    = 12;
    localparam int unsigned ADDR_W_DEF    = 10;
    localparam int unsigned DEPTH_DEF     = 1024;
    localparam int unsigned ROM_LAT_DEF   = 1;
    localparam int unsigned GAIN_W_DEF    = 18;
    localparam int unsigned GAIN_FRAC_DEF = 16;
    localparam int unsigned OUT_W_DEF     = 16;

    // ROM read latency plus the scale stage and the subtract/saturate stage.
    localparam int unsigned LAT = ROM_LAT_DEF + 2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } mode_e;

    // Clip v into [-2**(w-1), 2**(w-1)-1]. Callers keep w well below 64.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                                 input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/rom_error_dp.sv
// -----------------------------------------------------------------------------
// rom_error_dp
// Error datapath: delays the accepted sample's vref/gain/sof/valid to meet the
// ROM word, scales the word by the fixed-point gain (floor), subtracts from
// vref at full width and saturates to OUT_W signed.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_accept        sample accepted this cycle (ROM address presented now)
//   i_sof           accepted sample is from address 0
//   i_vref, i_gain  setpoint and gain of the accepted sample
//   i_rom_data      ROM word, valid ROM_LAT cycles after acceptance
//   o_e0            registered saturated error (holds between valids)
//   o_e0_valid      one-cycle pulse, ROM_LAT+2 cycles after i_accept
//   o_e0_sof/sat    start-of-frame / clipped flags, 0 outside valid pulses
// -----------------------------------------------------------------------------
module rom_error_dp
    import rom_error_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned GAIN_W    = GAIN_W_DEF,
    parameter int unsigned GAIN_FRAC = GAIN_FRAC_DEF,
    parameter int unsigned OUT_W     = OUT_W_DEF,
    parameter int unsigned ROM_LAT   = ROM_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_accept,
    input  logic                     i_sof,
    input  logic signed [OUT_W-1:0]  i_vref,
    input  logic [GAIN_W-1:0]        i_gain,
    input  logic [DATA_W-1:0]        i_rom_data,
    output logic signed [OUT_W-1:0]  o_e0,
    output logic                     o_e0_valid,
    output logic                     o_e0_sof,
    output logic                     o_e0_sat
);

    localparam int unsigned PW = DATA_W + GAIN_W;
    localparam int unsigned SW = PW - GAIN_FRAC;

    // Alignment shift register: entry ROM_LAT-1 lines up with i_rom_data.
    logic                    r_lat_v    [ROM_LAT];
    logic                    r_lat_sof  [ROM_LAT];
    logic signed [OUT_W-1:0] r_lat_vref [ROM_LAT];
    logic [GAIN_W-1:0]       r_lat_gain [ROM_LAT];

    logic                    r_a_v;
    logic                    r_a_sof;
    logic signed [OUT_W-1:0] r_a_vref;
    logic [SW-1:0]           r_a_scaled;

    logic [PW-1:0]           w_prod;
    logic [SW-1:0]           w_scaled;
    logic signed [63:0]      w_diff;
    logic signed [63:0]      w_sat;
    logic                    w_clip;

    always_comb begin
        w_prod   = PW'(i_rom_data) * PW'(r_lat_gain[ROM_LAT-1]);
        w_scaled = SW'(w_prod >> GAIN_FRAC);
        w_diff   = 64'(r_a_vref) - 64'(r_a_scaled);
        w_sat    = sat_s(w_diff, OUT_W);
        w_clip   = (w_sat != w_diff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                r_lat_v[i]    <= 1'b0;
                r_lat_sof[i]  <= 1'b0;
                r_lat_vref[i] <= '0;
                r_lat_gain[i] <= '0;
            end
            r_a_v      <= 1'b0;
            r_a_sof    <= 1'b0;
            r_a_vref   <= '0;
            r_a_scaled <= '0;
            o_e0       <= '0;
            o_e0_valid <= 1'b0;
            o_e0_sof   <= 1'b0;
            o_e0_sat   <= 1'b0;
        end else begin
            r_lat_v[0]    <= i_accept;
            r_lat_sof[0]  <= i_sof;
            r_lat_vref[0] <= i_vref;
            r_lat_gain[0] <= i_gain;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                r_lat_v[i]    <= r_lat_v[i-1];
                r_lat_sof[i]  <= r_lat_sof[i-1];
                r_lat_vref[i] <= r_lat_vref[i-1];
                r_lat_gain[i] <= r_lat_gain[i-1];
            end

            r_a_v      <= r_lat_v[ROM_LAT-1];
            r_a_sof    <= r_lat_sof[ROM_LAT-1];
            r_a_vref   <= r_lat_vref[ROM_LAT-1];
            r_a_scaled <= w_scaled;

            // e0 only moves on a valid sample; flags are gated by valid.
            if (r_a_v) begin
                o_e0 <= OUT_W'(w_sat);
            end
            o_e0_valid <= r_a_v;
            o_e0_sof   <= r_a_v & r_a_sof;
            o_e0_sat   <= r_a_v & w_clip;
        end
    end

endmodule

// File: rtl/rom_error_gen.sv
// -----------------------------------------------------------------------------
// rom_error_gen
// Steps a reference-table address on each accepted sample strobe, reads an
// external synchronous ROM and emits e0 = vref - gain*rom (saturated).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fs_en               sample strobe
//   run                 1 = accept fs_en, 0 = ignore and hold address
//   oneshot             1 = stop at DEPTH-1, 0 = wrap to 0
//   restart             synchronous clear of address and done (wins over fs_en)
//   vref, gain          setpoint / unsigned fixed-point gain, taken on accept
//   rom_addr, rom_data  ROM read port (ROM_LAT cycles of read latency)
//   e0, e0_valid        saturated error and its one-cycle strobe
//   e0_sof, e0_sat      sample from address 0 / sample was clipped
//   wrap                one-cycle pulse after the DEPTH-1 -> 0 step
//   done                one-shot playback finished
// -----------------------------------------------------------------------------
module rom_error_gen
    import rom_error_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned ROM_LAT   = ROM_LAT_DEF,
    parameter int unsigned GAIN_W    = GAIN_W_DEF,
    parameter int unsigned GAIN_FRAC = GAIN_FRAC_DEF,
    parameter int unsigned OUT_W     = OUT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fs_en,
    input  logic                     run,
    input  logic                     oneshot,
    input  logic                     restart,
    input  logic signed [OUT_W-1:0]  vref,
    input  logic [GAIN_W-1:0]        gain,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    output logic signed [OUT_W-1:0]  e0,
    output logic                     e0_valid,
    output logic                     e0_sof,
    output logic                     e0_sat,
    output logic                     wrap,
    output logic                     done
);

    mode_e             r_state;
    mode_e             w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wrap;
    logic              w_done;
    logic              w_last;
    logic              w_accept;

    assign w_last   = (r_addr == ADDR_W'(DEPTH - 1));
    assign w_accept = fs_en & run & ~restart & ~w_done;

    // Mode FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // Mode FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (w_accept && w_last && oneshot) w_state_nxt = ST_DONE;
            ST_DONE: if (restart)                       w_state_nxt = ST_RUN;
            default:                                    w_state_nxt = ST_RUN;
        endcase
    end

    // Mode FSM: outputs
    always_comb begin
        w_done = (r_state == ST_DONE);
    end

    // Address counter; holds at DEPTH-1 when a one-shot finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_accept & w_last & ~oneshot;
            if (restart) begin
                r_addr <= '0;
            end else if (w_accept) begin
                if (!w_last)       r_addr <= r_addr + 1'b1;
                else if (!oneshot) r_addr <= '0;
            end
        end
    end

    assign rom_addr = r_addr;
    assign wrap     = r_wrap;
    assign done     = w_done;

    rom_error_dp #(
        .DATA_W    (DATA_W),
        .GAIN_W    (GAIN_W),
        .GAIN_FRAC (GAIN_FRAC),
        .OUT_W     (OUT_W),
        .ROM_LAT   (ROM_LAT)
    ) u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_accept   (w_accept),
        .i_sof      (r_addr == '0),
        .i_vref     (vref),
        .i_gain     (gain),
        .i_rom_data (rom_data),
        .o_e0       (e0),
        .o_e0_valid (e0_valid),
        .o_e0_sof   (e0_sof),
        .o_e0_sat   (e0_sat)
    );

endmodule

// File: tb/tb_rom_error_gen.sv
// -----------------------------------------------------------------------------
// tb_rom_error_gen
// Directed bench for rom_error_gen with an 8-entry table and a 1-cycle
// synchronous ROM model. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_rom_error_gen;

    logic               clk;
    logic               rst_n;
    logic               fs_en;
    logic               run;
    logic               oneshot;
    logic               restart;
    logic signed [15:0] vref;
    logic [17:0]        gain;
    logic [3:0]         rom_addr;
    logic [11:0]        rom_data;
    logic signed [15:0] e0;
    logic               e0_valid;
    logic               e0_sof;
    logic               e0_sat;
    logic               wrap;
    logic               done;

    logic [11:0]        rom_mem [16];

    int                 cyc     = 0;
    int                 n_chk   = 0;
    int                 n_pass  = 0;
    int                 n_stray = 0;

    logic signed [15:0] q_e0  [$];
    bit                 q_sof [$];
    bit                 q_sat [$];
    int                 q_cyc [$];
    int                 q_wrap[$];

    localparam logic [17:0] G1 = 18'h10000;

    rom_error_gen #(
        .DATA_W    (12),
        .ADDR_W    (4),
        .DEPTH     (8),
        .ROM_LAT   (1),
        .GAIN_W    (18),
        .GAIN_FRAC (16),
        .OUT_W     (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fs_en    (fs_en),
        .run      (run),
        .oneshot  (oneshot),
        .restart  (restart),
        .vref     (vref),
        .gain     (gain),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .e0       (e0),
        .e0_valid (e0_valid),
        .e0_sof   (e0_sof),
        .e0_sat   (e0_sat),
        .wrap     (wrap),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    always @(negedge clk) begin
        if (e0_valid) begin
            q_e0.push_back(e0);
            q_sof.push_back(e0_sof);
            q_sat.push_back(e0_sat);
            q_cyc.push_back(cyc);
        end else if (e0_sof || e0_sat) begin
            n_stray++;
        end
        if (wrap) q_wrap.push_back(cyc);
    end

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_q();
        q_e0.delete(); q_sof.delete(); q_sat.delete(); q_cyc.delete(); q_wrap.delete();
    endtask

    task automatic rom_identity();
        for (int i = 0; i < 16; i++) rom_mem[i] = 12'(i);
    endtask

    // Called just after a negedge; returns one cycle later, fs_en low again.
    task automatic strobe(input logic signed [15:0] v, input logic [17:0] g,
                          output int t);
        vref  = v;
        gain  = g;
        fs_en = 1'b1;
        t     = cyc;
        @(negedge clk);
        fs_en = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_addr"},  rom_addr, 0);
        chk({pfx, "_done"},  done,     0);
        chk({pfx, "_wrap"},  wrap,     0);
        chk({pfx, "_e0"},    e0,       0);
        chk({pfx, "_valid"}, e0_valid, 0);
        chk({pfx, "_sof"},   e0_sof,   0);
        chk({pfx, "_sat"},   e0_sat,   0);
    endtask

    initial begin
        int t1[4];
        int t0;
        int ta;
        int tb;
        int tc;

        rst_n = 1'b1; fs_en = 1'b0; run = 1'b1; oneshot = 1'b0; restart = 1'b0;
        vref = '0; gain = '0;
        rom_identity();
        #2 rst_n = 1'b0;
        ticks(2);
        chk_zero("rst");
        rst_n = 1'b1;
        ticks(1);

        // Gain 1.0, vref 100, strobe every 4 cycles: 100,99,98,97 at +3.
        clr_q();
        for (int k = 0; k < 4; k++) begin
            chk("t1_addr", rom_addr, k);
            strobe(16'sd100, G1, t1[k]);
            ticks(3);
        end
        ticks(2);
        chk("t1_count", q_e0.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("t1_e0",  q_e0[k], 100 - k);
            chk("t1_sof", q_sof[k], (k == 0) ? 1 : 0);
            chk("t1_sat", q_sat[k], 0);
            chk("t1_lat", q_cyc[k] - t1[k], 3);
        end

        // Continuous wrap, back-to-back strobes.
        clr_q();
        do_restart();
        t0 = 0;
        vref = 16'sd100; gain = G1;
        for (int k = 0; k < 16; k++) begin
            chk("t2_addr", rom_addr, k % 8);
            fs_en = 1'b1;
            if (k == 0) t0 = cyc;
            @(negedge clk);
        end
        fs_en = 1'b0;
        ticks(4);
        chk("t2_count", q_e0.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_e0",  q_e0[i], 100 - (i % 8));
            chk("t2_sof", q_sof[i], (i % 8 == 0) ? 1 : 0);
            chk("t2_cyc", q_cyc[i], t0 + 3 + i);
        end
        chk("t2_wrap_n", q_wrap.size(), 2);
        chk("t2_wrap0", q_wrap[0], t0 + 8);
        chk("t2_wrap1", q_wrap[1], t0 + 16);
        chk("t2_hold",  e0, 93);
        chk("t2_idle",  e0_valid, 0);

        // Scaling and saturation, vref/gain changing per strobe.
        clr_q();
        rom_mem[0] = 12'd4095; rom_mem[1] = 12'd4095; rom_mem[2] = 12'd0;
        chk("t3_addr", rom_addr, 0);
        strobe(16'sd15, 18'd320, ta);
        strobe(-16'sd32768, G1, tb);
        strobe(16'sd32767, G1, tc);
        ticks(4);
        chk("t3_count", q_e0.size(), 3);
        chk("t3_scale_e0",  q_e0[0], -4);
        chk("t3_scale_sat", q_sat[0], 0);
        chk("t3_scale_sof", q_sof[0], 1);
        chk("t3_neg_e0",    q_e0[1], -32768);
        chk("t3_neg_sat",   q_sat[1], 1);
        chk("t3_pos_e0",    q_e0[2], 32767);
        chk("t3_pos_sat",   q_sat[2], 0);
        chk("t3_lat",       q_cyc[2] - tc, 3);
        rom_identity();

        // One-shot: 10 strobes, 8 accepted, done after the 8th.
        clr_q();
        do_restart();
        oneshot = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("t4_done_pre", done, (k >= 8) ? 1 : 0);
            strobe(16'sd100, G1, ta);
            chk("t4_done", done, (k >= 7) ? 1 : 0);
            chk("t4_addr", rom_addr, (k < 7) ? k + 1 : 7);
            ticks(1);
        end
        ticks(4);
        chk("t4_count", q_e0.size(), 8);
        for (int i = 0; i < 8; i++) chk("t4_e0", q_e0[i], 100 - i);
        chk("t4_nowrap", q_wrap.size(), 0);
        clr_q();
        restart = 1'b1; fs_en = 1'b1;
        @(negedge clk);
        restart = 1'b0; fs_en = 1'b0;
        chk("t4_rs_done", done, 0);
        chk("t4_rs_addr", rom_addr, 0);
        ticks(5);
        chk("t4_rs_drop", q_e0.size(), 0);
        oneshot = 1'b0;

        // run=0 after one accepted strobe: address frozen, one valid only.
        clr_q();
        strobe(16'sd100, G1, ta);
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            strobe(16'sd100, G1, tb);
            chk("t5_addr", rom_addr, 1);
            ticks(1);
        end
        run = 1'b1;
        ticks(3);
        chk("t5_count", q_e0.size(), 1);
        chk("t5_e0",    q_e0[0], 100);
        chk("t5_sof",   q_sof[0], 1);

        // Reset with two samples in flight.
        clr_q();
        strobe(16'sd100, G1, ta);
        strobe(16'sd100, G1, tb);
        rst_n = 1'b0;
        #1;
        chk_zero("t6_rst");
        ticks(3);
        chk("t6_flush", q_e0.size(), 0);
        chk_zero("t6_rst_hold");
        rst_n = 1'b1;
        ticks(1);
        chk("t6_addr", rom_addr, 0);
        strobe(16'sd100, G1, tc);
        ticks(4);
        chk("t6_count", q_e0.size(), 1);
        chk("t6_e0",    q_e0[0], 100);
        chk("t6_sof",   q_sof[0], 1);
        chk("t6_lat",   q_cyc[0] - tc, 3);

        chk("stray_flags", n_stray, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
